// File: rtl/uart_cmd_decoder.sv
// UART command-frame decoder: parses SYNC/CMD/ADDR/DATA_H/DATA_L[/CHK] frames, issues register strobes and
// queues ACK/NAK/read-data responses. Define UART_CMD_CHK_EN to require and verify the XOR checksum byte.
module uart_cmd_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        sys_clk,
  input  logic        sys_nrst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic        tx_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  output logic        reg_wr_en,
  output logic        reg_rd_en,
  output logic [7:0]  reg_addr,
  output logic [15:0] reg_wdata,
  input  logic [15:0] reg_rdata,
  output logic [7:0]  err_cnt
);

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DH, S_DL, S_CHK, S_EXEC, S_RESP
  } state_t;

  typedef enum logic [1:0] {
    R_ACK, R_READ, R_NAK
  } resp_t;

  state_t          state_q, state_d;
  resp_t           resp_q, resp_d;
  logic [7:0]      cmd_q, cmd_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      dh_q, dh_d;
  logic [7:0]      dl_q, dl_d;
  logic            chk_ok_q, chk_ok_d;
  logic [15:0]     rdata_q, rdata_d;
  logic [1:0]      idx_q, idx_d;
  logic [CW-1:0]   to_cnt_q, to_cnt_d;
  logic [7:0]      err_q, err_d;
`ifdef UART_CMD_CHK_EN
  logic [7:0]      chk_q, chk_d;
`endif

  logic receiving;
  logic err_inc;
  logic resp_last;

  assign reg_addr  = addr_q;
  assign reg_wdata = {dh_q, dl_q};
  assign err_cnt   = err_q;

  always_ff @(posedge sys_clk or negedge sys_nrst) begin
    if (!sys_nrst) begin
      state_q  <= S_IDLE;
      resp_q   <= R_ACK;
      cmd_q    <= 8'h00;
      addr_q   <= 8'h00;
      dh_q     <= 8'h00;
      dl_q     <= 8'h00;
      chk_ok_q <= 1'b0;
      rdata_q  <= 16'h0000;
      idx_q    <= 2'd0;
      to_cnt_q <= '0;
      err_q    <= 8'h00;
`ifdef UART_CMD_CHK_EN
      chk_q    <= 8'h00;
`endif
    end else begin
      state_q  <= state_d;
      resp_q   <= resp_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      dh_q     <= dh_d;
      dl_q     <= dl_d;
      chk_ok_q <= chk_ok_d;
      rdata_q  <= rdata_d;
      idx_q    <= idx_d;
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
`ifdef UART_CMD_CHK_EN
      chk_q    <= chk_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    resp_d    = resp_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    dh_d      = dh_q;
    dl_d      = dl_q;
    chk_ok_d  = chk_ok_q;
    rdata_d   = rdata_q;
    idx_d     = idx_q;
    to_cnt_d  = to_cnt_q;
    err_d     = err_q;
`ifdef UART_CMD_CHK_EN
    chk_d     = chk_q;
`endif
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    reg_wr_en = 1'b0;
    reg_rd_en = 1'b0;
    err_inc   = 1'b0;
    resp_last = (resp_q != R_READ) || (idx_q == 2'd2);

    receiving = (state_q == S_CMD) || (state_q == S_ADDR) ||
                (state_q == S_DH)  || (state_q == S_DL)   || (state_q == S_CHK);

    // Inter-byte timeout is shared by every receive state.
    if (receiving) begin
      if (rx_valid) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        to_cnt_d = '0;
        state_d  = S_IDLE;
        err_inc  = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        to_cnt_d = '0;
        if (rx_valid && (rx_data == SYNC_BYTE)) begin
          state_d  = S_CMD;
          chk_ok_d = 1'b1;
`ifdef UART_CMD_CHK_EN
          chk_d    = 8'h00;
`endif
        end
      end
      S_CMD: begin
        if (rx_valid) begin
          cmd_d   = rx_data;
          state_d = S_ADDR;
`ifdef UART_CMD_CHK_EN
          chk_d   = chk_q ^ rx_data;
`endif
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          state_d = S_DH;
`ifdef UART_CMD_CHK_EN
          chk_d   = chk_q ^ rx_data;
`endif
        end
      end
      S_DH: begin
        if (rx_valid) begin
          dh_d    = rx_data;
          state_d = S_DL;
`ifdef UART_CMD_CHK_EN
          chk_d   = chk_q ^ rx_data;
`endif
        end
      end
      S_DL: begin
        if (rx_valid) begin
          dl_d    = rx_data;
`ifdef UART_CMD_CHK_EN
          chk_d   = chk_q ^ rx_data;
          state_d = S_CHK;
`else
          state_d = S_EXEC;
`endif
        end
      end
      S_CHK: begin
`ifdef UART_CMD_CHK_EN
        if (rx_valid) begin
          chk_ok_d = (rx_data == chk_q);
          state_d  = S_EXEC;
        end
`else
        state_d = S_IDLE;
`endif
      end
      S_EXEC: begin
        idx_d   = 2'd0;
        state_d = S_RESP;
        if (chk_ok_q && (cmd_q == CMD_WRITE)) begin
          reg_wr_en = 1'b1;
          resp_d    = R_ACK;
        end else if (chk_ok_q && (cmd_q == CMD_READ)) begin
          reg_rd_en = 1'b1;
          rdata_d   = reg_rdata;
          resp_d    = R_READ;
        end else begin
          err_inc = 1'b1;
          resp_d  = R_NAK;
        end
      end
      S_RESP: begin
        case (resp_q)
          R_ACK:   tx_data = ACK_BYTE;
          R_NAK:   tx_data = NAK_BYTE;
          default: begin
            case (idx_q)
              2'd0:    tx_data = SYNC_BYTE;
              2'd1:    tx_data = rdata_q[15:8];
              default: tx_data = rdata_q[7:0];
            endcase
          end
        endcase
        // The byte is held in place until the transmitter has room.
        if (!tx_full) begin
          tx_valid = 1'b1;
          if (resp_last) begin
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (err_inc && (err_q != 8'hFF)) begin
      err_d = err_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed bench for uart_cmd_decoder: write, read, bad checksum, backpressure, timeout and mid-frame reset.
module tb_uart_cmd_decoder;

  logic        sys_clk;
  logic        sys_nrst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_full;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        reg_wr_en;
  logic        reg_rd_en;
  logic [7:0]  reg_addr;
  logic [15:0] reg_wdata;
  logic [15:0] reg_rdata;
  logic [7:0]  err_cnt;

  int tests;
  int fails;

  int wr_cnt;
  int rd_cnt;
  int full_viol;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic [7:0]  rd_addr;
  logic [7:0]  tx_log [0:255];
  int tx_n;

  logic [7:0] fr [0:8];
  int w0, r0, t0, v0;
  int exp_err;

  uart_cmd_decoder #(.TIMEOUT_CYCLES(16)) dut (
    .sys_clk   (sys_clk),
    .sys_nrst  (sys_nrst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .tx_full   (tx_full),
    .tx_valid  (tx_valid),
    .tx_data   (tx_data),
    .reg_wr_en (reg_wr_en),
    .reg_rd_en (reg_rd_en),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .err_cnt   (err_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    wr_cnt = 0; rd_cnt = 0; full_viol = 0; tx_n = 0;
    wr_addr = 8'h00; wr_data = 16'h0000; rd_addr = 8'h00;
  end

  always @(negedge sys_clk) begin
    if (sys_nrst) begin
      if (reg_wr_en) begin
        wr_cnt  = wr_cnt + 1;
        wr_addr = reg_addr;
        wr_data = reg_wdata;
      end
      if (reg_rd_en) begin
        rd_cnt  = rd_cnt + 1;
        rd_addr = reg_addr;
      end
      if (tx_valid) begin
        if (tx_full) full_viol = full_viol + 1;
        if (tx_n < 256) tx_log[tx_n] = tx_data;
        tx_n = tx_n + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge sys_clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge sys_clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_seq(input int n, input string name);
    for (int i = 0; i < n; i++) send_byte(fr[i]);
    $display("[TB] sent %s (%0d bytes)", name, n);
  endtask

  task automatic snap();
    w0 = wr_cnt; r0 = rd_cnt; t0 = tx_n; v0 = full_viol;
  endtask

  task automatic settle(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_txv"},   {31'd0, tx_valid},  32'd0);
    check({tag, "_wr"},    {31'd0, reg_wr_en}, 32'd0);
    check({tag, "_rd"},    {31'd0, reg_rd_en}, 32'd0);
    check({tag, "_txd"},   {24'd0, tx_data},   32'd0);
    check({tag, "_addr"},  {24'd0, reg_addr},  32'd0);
    check({tag, "_wdata"}, {16'd0, reg_wdata}, 32'd0);
    check({tag, "_err"},   {24'd0, err_cnt},   32'd0);
  endtask

  initial begin
    tests = 0; fails = 0; exp_err = 0;
    sys_nrst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_full = 1'b0;
    reg_rdata = 16'hBEEF;
    #12;
    check_all_zero("reset");
    @(negedge sys_clk); sys_nrst = 1'b1;
    settle(2);

    // Write frame
    snap();
    fr[0] = 8'hA5; fr[1] = 8'h01; fr[2] = 8'h10; fr[3] = 8'h12; fr[4] = 8'h34; fr[5] = 8'h37;
    send_seq(6, "write A5 01 10 12 34 37");
    settle(8);
    check("wr_pulses", wr_cnt - w0, 1);
    check("wr_no_rd", rd_cnt - r0, 0);
    check("wr_addr", {24'd0, wr_addr}, 32'h10);
    check("wr_data", {16'd0, wr_data}, 32'h1234);
    check("wr_held_addr", {24'd0, reg_addr}, 32'h10);
    check("wr_held_wdata", {16'd0, reg_wdata}, 32'h1234);
    check("wr_tx_count", tx_n - t0, 1);
    check("wr_tx_ack", {24'd0, tx_log[t0]}, 32'h06);

    // Read frame
    snap();
    fr[0] = 8'hA5; fr[1] = 8'h02; fr[2] = 8'h20; fr[3] = 8'h00; fr[4] = 8'h00; fr[5] = 8'h22;
    send_seq(6, "read A5 02 20 00 00 22");
    settle(8);
    check("rd_pulses", rd_cnt - r0, 1);
    check("rd_no_wr", wr_cnt - w0, 0);
    check("rd_addr", {24'd0, rd_addr}, 32'h20);
    check("rd_tx_count", tx_n - t0, 3);
    check("rd_tx0", {24'd0, tx_log[t0]}, 32'hA5);
    check("rd_tx1", {24'd0, tx_log[t0+1]}, 32'hBE);
    check("rd_tx2", {24'd0, tx_log[t0+2]}, 32'hEF);

    // Bad checksum frame
    snap();
    fr[0] = 8'hA5; fr[1] = 8'h01; fr[2] = 8'h10; fr[3] = 8'h12; fr[4] = 8'h34; fr[5] = 8'h00;
    send_seq(6, "badchk A5 01 10 12 34 00");
    settle(8);
`ifdef UART_CMD_CHK_EN
    exp_err = exp_err + 1;
    check("bad_no_wr", wr_cnt - w0, 0);
    check("bad_no_rd", rd_cnt - r0, 0);
    check("bad_tx_count", tx_n - t0, 1);
    check("bad_tx_nak", {24'd0, tx_log[t0]}, 32'h15);
`else
    check("nochk_wr", wr_cnt - w0, 1);
    check("nochk_tx_count", tx_n - t0, 1);
    check("nochk_tx_ack", {24'd0, tx_log[t0]}, 32'h06);
`endif
    check("bad_err_cnt", {24'd0, err_cnt}, exp_err);

    // Backpressure on a read response
    snap();
    tx_full = 1'b1;
    fr[0] = 8'hA5; fr[1] = 8'h02; fr[2] = 8'h20; fr[3] = 8'h00; fr[4] = 8'h00; fr[5] = 8'h22;
    send_seq(6, "read under tx_full");
    settle(50);
    check("bp_none_while_full", tx_n - t0, 0);
    tx_full = 1'b0;
    settle(1);
    tx_full = 1'b1;
    settle(10);
    check("bp_one_after_gap", tx_n - t0, 1);
    tx_full = 1'b0;
    settle(8);
    check("bp_rd_pulses", rd_cnt - r0, 1);
    check("bp_tx_count", tx_n - t0, 3);
    check("bp_tx0", {24'd0, tx_log[t0]}, 32'hA5);
    check("bp_tx1", {24'd0, tx_log[t0+1]}, 32'hBE);
    check("bp_tx2", {24'd0, tx_log[t0+2]}, 32'hEF);
    check("bp_no_push_when_full", full_viol - v0, 0);

    // Inter-byte timeout after A5 01
    snap();
    fr[0] = 8'hA5; fr[1] = 8'h01;
    send_seq(2, "partial A5 01");
    settle(13);
    check("to_not_yet", {24'd0, err_cnt}, exp_err);
    settle(5);
    exp_err = exp_err + 1;
    check("to_err_inc", {24'd0, err_cnt}, exp_err);
    check("to_no_tx", tx_n - t0, 0);
    fr[0] = 8'hA5; fr[1] = 8'h01; fr[2] = 8'h20; fr[3] = 8'h56; fr[4] = 8'h78; fr[5] = 8'h0F;
    send_seq(6, "write A5 01 20 56 78 0F");
    settle(8);
    check("to_next_wr", wr_cnt - w0, 1);
    check("to_next_addr", {24'd0, wr_addr}, 32'h20);
    check("to_next_data", {16'd0, wr_data}, 32'h5678);
    check("to_next_ack", {24'd0, tx_log[t0]}, 32'h06);
    check("to_next_err", {24'd0, err_cnt}, exp_err);

    // Reset in the middle of a frame
    fr[0] = 8'hA5; fr[1] = 8'h01; fr[2] = 8'h10;
    send_seq(3, "partial A5 01 10");
    @(posedge sys_clk); #1;
    sys_nrst = 1'b0;
    #2;
    check_all_zero("midrst");
    @(negedge sys_clk); sys_nrst = 1'b1;
    #1;
    check("rel_no_strobe", {30'd0, reg_wr_en, reg_rd_en}, 32'd0);
    check("rel_no_txv", {31'd0, tx_valid}, 32'd0);
    snap();
    fr[0] = 8'h12; fr[1] = 8'h34; fr[2] = 8'h37;
    fr[3] = 8'hA5; fr[4] = 8'h01; fr[5] = 8'h10; fr[6] = 8'h12; fr[7] = 8'h34; fr[8] = 8'h37;
    send_seq(9, "12 34 37 A5 01 10 12 34 37");
    settle(8);
    check("rst_one_wr", wr_cnt - w0, 1);
    check("rst_wr_addr", {24'd0, wr_addr}, 32'h10);
    check("rst_tx_count", tx_n - t0, 1);
    check("rst_tx_ack", {24'd0, tx_log[t0]}, 32'h06);
    check("rst_err", {24'd0, err_cnt}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
